// File: rtl/decode_stream.sv
// decode_stream: 24-bit MSB-first bit aligner feeding decode_ctl with a 13-bit window.
// Handles byte loading, variable-width consume, end-of-input drain, end-marker flush and underrun.
module decode_stream (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ack,
  output logic [12:0] stream_data,
  output logic        stream_valid,
  input  logic [3:0]  stream_width,
  input  logic        stream_ack,
  input  logic        all_end,
  output logic        stream_err
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_FLUSH, S_DONE} state_t;

  state_t      state;
  logic [23:0] bit_buf;
  logic [4:0]  cnt;
  logic        last_seen;

  logic [3:0]  w;
  logic [5:0]  rem;
  logic [4:0]  cnt_sat;
  logic [23:0] shifted;
  logic [23:0] loaded;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    stream_data  = bit_buf[23:11];
    stream_valid = 1'b0;
    in_ack       = 1'b0;
    w            = 4'd0;

    case (state)
      S_RUN:   stream_valid = (cnt >= 5'd13);
      S_DRAIN: stream_valid = (cnt != 5'd0);
      default: stream_valid = 1'b0;
    endcase

    if (stream_ack && stream_valid)
      w = (stream_width > 4'd13) ? 4'd13 : stream_width;

    // rem is signed in effect: it only goes negative when a drain consume overshoots.
    rem     = {1'b0, cnt} - {2'b00, w};
    cnt_sat = rem[5] ? 5'd0 : rem[4:0];

    case (state)
      S_RUN:   in_ack = in_valid && !all_end && (rem <= 6'd16);
      S_FLUSH: in_ack = in_valid;
      default: in_ack = 1'b0;
    endcase

    // The new byte lands directly below the bits that survive this cycle's consume.
    shifted = bit_buf << w;
    loaded  = shifted | ({in_data, 16'h0000} >> rem);
  end

  // NOTE: synchronous reset checked first inside the clocked block; state updates use <= only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      bit_buf    <= '0;
      cnt        <= '0;
      last_seen  <= 1'b0;
      stream_err <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (all_end) begin
            bit_buf <= '0;
            cnt     <= '0;
            state   <= last_seen ? S_DONE : S_FLUSH;
          end else begin
            bit_buf <= in_ack ? loaded : shifted;
            cnt     <= rem[4:0] + (in_ack ? 5'd8 : 5'd0);
            if (in_ack && in_last) begin
              last_seen <= 1'b1;
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (all_end) begin
            bit_buf <= '0;
            cnt     <= '0;
            state   <= last_seen ? S_DONE : S_FLUSH;
          end else begin
            bit_buf <= shifted;
            cnt     <= cnt_sat;
            if (cnt_sat == 5'd0) begin
              stream_err <= 1'b1;
              state      <= S_DONE;
            end
          end
        end
        S_FLUSH: begin
          if (in_valid && in_last)
            state <= S_DONE;
        end
        default: state <= S_DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_stream.sv
// Self-checking bench for decode_stream: directed steps plus randomized streams
// compared every cycle against a bit-queue reference model.
module tb_decode_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ack;
  logic [12:0] stream_data;
  logic        stream_valid;
  logic [3:0]  stream_width;
  logic        stream_ack;
  logic        all_end;
  logic        stream_err;

  decode_stream dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ack       (in_ack),
    .stream_data  (stream_data),
    .stream_valid (stream_valid),
    .stream_width (stream_width),
    .stream_ack   (stream_ack),
    .all_end      (all_end),
    .stream_err   (stream_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the unconsumed bits in stream order plus phase flags.
  bit mq[$];
  bit m_last, m_flush, m_done, m_err;
  logic last_ack;
  logic exp_ack_g;

  logic        r_v, r_l, r_a, r_e;
  logic [7:0]  r_d;
  logic [3:0]  r_w;
  int          nbytes, sent;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    mq.delete();
    m_last  = 1'b0;
    m_flush = 1'b0;
    m_done  = 1'b0;
    m_err   = 1'b0;
  endfunction

  function automatic logic m_valid();
    if (m_done || m_flush) return 1'b0;
    if (m_last) return (mq.size() != 0);
    return (mq.size() >= 13);
  endfunction

  function automatic logic [12:0] m_data();
    logic [12:0] r = '0;
    for (int i = 0; i < 13; i++)
      if (i < mq.size()) r[12-i] = mq[i];
    return r;
  endfunction

  // One clock: apply inputs, compare all outputs with the model, then advance both.
  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic a, input logic [3:0] wd, input logic e, input logic r);
    logic ev, ea;
    int   w, avail;
    in_valid = v; in_data = d; in_last = l;
    stream_ack = a; stream_width = wd; all_end = e; rst = r;
    #1;
    ev = m_valid();
    w  = (a && ev) ? ((wd > 13) ? 13 : int'(wd)) : 0;
    if (m_done)       ea = 1'b0;
    else if (m_flush) ea = v;
    else if (m_last)  ea = 1'b0;
    else              ea = v && !e && ((mq.size() - w) <= 16);
    check("stream_valid", stream_valid, ev);
    check("stream_data", stream_data, m_data());
    check("in_ack", in_ack, ea);
    check("stream_err", stream_err, m_err);
    last_ack  = in_ack;
    exp_ack_g = ea;
    @(posedge clk);
    if (r) begin
      m_reset();
    end else if (m_done) begin
    end else if (m_flush) begin
      if (v && l) m_done = 1'b1;
    end else if (e) begin
      mq.delete();
      if (m_last) m_done = 1'b1;
      else        m_flush = 1'b1;
    end else if (m_last) begin
      avail = mq.size();
      repeat ((w > avail) ? avail : w) void'(mq.pop_front());
      if (mq.size() == 0) begin
        m_err  = 1'b1;
        m_done = 1'b1;
      end
    end else begin
      repeat (w) void'(mq.pop_front());
      if (ea) begin
        for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
        if (l) m_last = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    in_valid = 0; in_data = 0; in_last = 0; stream_ack = 0;
    stream_width = 0; all_end = 0; rst = 1;
    @(posedge clk);
    @(negedge clk);
    m_reset();

    // Reset state
    step(0, 8'h00, 0, 0, 4'd0, 0, 1);
    check("rst_valid", stream_valid, 0);
    check("rst_data", stream_data, 0);
    check("rst_err", stream_err, 0);

    // Fill to 24 bits, fourth byte held off
    step(1, 8'hAB, 0, 0, 4'd0, 0, 0);
    step(1, 8'hCD, 0, 0, 4'd0, 0, 0);
    check("fill_valid", stream_valid, 1);
    check("fill_data", stream_data, 13'h1579);
    step(1, 8'hEF, 0, 0, 4'd0, 0, 0);
    check("third_ack", last_ack, 1);
    step(1, 8'h11, 0, 0, 4'd0, 0, 0);
    check("fourth_held", last_ack, 0);

    // Consume 9 of 16, then refill
    step(0, 8'h00, 0, 0, 4'd0, 0, 1);
    step(1, 8'hAB, 0, 0, 4'd0, 0, 0);
    step(1, 8'hCD, 0, 0, 4'd0, 0, 0);
    step(0, 8'h00, 0, 1, 4'd9, 0, 0);
    check("w9_valid", stream_valid, 0);
    step(1, 8'h80, 0, 0, 4'd0, 0, 0);
    check("w9_refill", stream_data, 13'h1360);

    // Consume 13 and load in the same cycle
    step(0, 8'h00, 0, 0, 4'd0, 0, 1);
    step(1, 8'hAB, 0, 0, 4'd0, 0, 0);
    step(1, 8'hCD, 0, 0, 4'd0, 0, 0);
    step(1, 8'h55, 0, 1, 4'd13, 0, 0);
    check("w13_ack", last_ack, 1);
    check("w13_data", stream_data, 13'h1554);
    check("w13_valid", stream_valid, 0);

    // Ack while invalid ignored; width 15 clamps to 13
    step(0, 8'h00, 0, 0, 4'd0, 0, 1);
    step(1, 8'hAB, 0, 1, 4'd5, 0, 0);
    step(1, 8'hCD, 0, 1, 4'd5, 0, 0);
    check("ign_data", stream_data, 13'h1579);
    step(0, 8'h00, 0, 1, 4'd15, 0, 0);
    check("clamp_data", stream_data, 13'h1400);

    // End marker in drain, then all_end
    step(0, 8'h00, 0, 0, 4'd0, 0, 1);
    step(1, 8'hC0, 0, 0, 4'd0, 0, 0);
    step(1, 8'h00, 1, 0, 4'd0, 0, 0);
    check("marker_data", stream_data, 13'h1800);
    check("marker_valid", stream_valid, 1);
    step(0, 8'h00, 0, 0, 4'd0, 1, 0);
    check("end_valid", stream_valid, 0);
    step(1, 8'h22, 0, 0, 4'd0, 0, 0);
    check("done_no_ack", last_ack, 0);

    // all_end before last byte: pad bytes flushed
    step(0, 8'h00, 0, 0, 4'd0, 0, 1);
    step(0, 8'h00, 0, 0, 4'd0, 1, 0);
    step(1, 8'h00, 0, 0, 4'd0, 0, 0);
    check("pad1_ack", last_ack, 1);
    step(1, 8'h00, 1, 0, 4'd0, 0, 0);
    check("pad2_ack", last_ack, 1);
    step(1, 8'h33, 0, 0, 4'd0, 0, 0);
    check("flush_done", last_ack, 0);
    check("flush_err", stream_err, 0);

    // Drain underrun, then reset clears it
    step(0, 8'h00, 0, 0, 4'd0, 0, 1);
    step(1, 8'h12, 1, 0, 4'd0, 0, 0);
    step(0, 8'h00, 0, 1, 4'd9, 0, 0);
    check("underrun_err", stream_err, 1);
    check("underrun_valid", stream_valid, 0);
    step(0, 8'h00, 0, 0, 4'd0, 0, 1);
    check("rst_clears_err", stream_err, 0);
    step(1, 8'h44, 0, 0, 4'd0, 0, 0);
    check("run_after_rst", last_ack, 1);

    // Randomized streams
    for (int run = 0; run < 24; run++) begin
      step(0, 8'h00, 0, 0, 4'd0, 0, 1);
      nbytes = $urandom_range(2, 40);
      sent   = 0;
      for (int c = 0; c < 400 && !m_done; c++) begin
        r_v = ($urandom_range(0, 9) < 8);
        r_d = 8'($urandom);
        r_l = m_flush ? ($urandom_range(0, 3) == 0) : (sent == nbytes - 1);
        r_a = ($urandom_range(0, 9) < 7);
        r_w = 4'($urandom_range(0, 15));
        r_e = m_last ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 299) == 0);
        step(r_v, r_d, r_l, r_a, r_w, r_e, 0);
        if (exp_ack_g) sent++;
      end
      step(1, 8'h5A, 0, 1, 4'd4, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
